// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a-b-bi, LSB first, one bit per clock.
// Registered difference and per-bit borrows, with a one-cycle done pulse.
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bi,
   output logic [WIDTH-1:0] d,
   output logic [WIDTH-2:0] bo,
   output logic             bout,
   output logic             ready,
   output logic             busy,
   output logic             done
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;
   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, d_q, d_d;
   logic [WIDTH-2:0] bo_q, bo_d;
   logic             br_q, br_d, bout_q, bout_d, diff, br_next;
   always_comb begin
      diff    = a_q[0] ^ b_q[0] ^ br_q;
      br_next = (~a_q[0] & b_q[0]) | (~a_q[0] & br_q) | (b_q[0] & br_q);
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      br_d    = br_q;
      d_d     = d_q;
      bo_d    = bo_q;
      bout_d  = bout_q;
      if (state_q == IDLE && start) begin
         a_d     = a;
         b_d     = b;
         br_d    = bi;
         cnt_d   = '0;
         state_d = SHIFT;
      end else if (state_q == SHIFT) begin
         // operands shift right so the bit under process is always at index 0
         a_d   = a_q >> 1;
         b_d   = b_q >> 1;
         br_d  = br_next;
         cnt_d = cnt_q + 1'b1;
         for (int i = 0; i < WIDTH; i++)
            if (cnt_q == CW'(i)) d_d[i] = diff;
         for (int i = 0; i < WIDTH - 1; i++)
            if (cnt_q == CW'(i)) bo_d[i] = br_next;
         if (cnt_q == CW'(WIDTH - 1)) begin
            bout_d  = br_next;
            state_d = DONE;
         end
      end else if (state_q != IDLE) begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         br_q    <= 1'b0;
         d_q     <= '0;
         bo_q    <= '0;
         bout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         br_q    <= br_d;
         d_q     <= d_d;
         bo_q    <= bo_d;
         bout_q  <= bout_d;
      end
   end
   assign d     = d_q;
   assign bo    = bo_q;
   assign bout  = bout_q;
   assign ready = (state_q == IDLE);
   assign busy  = (state_q == SHIFT);
   assign done  = (state_q == DONE);
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed literal cases plus randomized traffic,
// checked each cycle against an arithmetic timeline model of the subtractor.
module tb_serial_subtractor;
   localparam int W = 4;
   logic         clk = 1'b0, rst, start, bi;
   logic [W-1:0] a, b, d;
   logic [W-2:0] bo;
   logic         bout, ready, busy, done;
   int           vecs = 0, errs = 0;
   logic         en = 1'b0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bi(bi),
      .d(d), .bo(bo), .bout(bout), .ready(ready), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] ref_d(input logic [W-1:0] x, y, input logic c);
      return x - y - {{(W-1){1'b0}}, c};
   endfunction

   // borrow out of bit i is simply whether the low i+1 bits of x fall short of y+c
   function automatic logic [W-1:0] ref_br(input logic [W-1:0] x, y, input logic c);
      logic [W-1:0] r;
      for (int i = 0; i < W; i++) begin
         int m = 1 << (i + 1);
         r[i] = (int'(x) % m) < (int'(y) % m) + int'(c);
      end
      return r;
   endfunction

   // m_t: -1 when idle, else clock edges elapsed since the accepting edge
   int           m_t = -1;
   logic [W-1:0] m_d = '0, p_d = '0;
   logic [W-2:0] m_bo = '0, p_bo = '0;
   logic         m_bout = 1'b0, p_bout = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_t <= -1; m_d <= '0; m_bo <= '0; m_bout <= 1'b0;
      end else if (m_t < 0) begin
         if (start) begin
            m_t    <= 0;
            p_d    <= ref_d(a, b, bi);
            p_bo   <= ref_br(a, b, bi)[W-2:0];
            p_bout <= ref_br(a, b, bi)[W-1];
         end
      end else if (m_t == W - 1) begin
         m_t <= W; m_d <= p_d; m_bo <= p_bo; m_bout <= p_bout;
      end else if (m_t == W) begin
         m_t <= -1;
      end else begin
         m_t <= m_t + 1;
      end
   end

   always @(negedge clk) begin
      if (en) begin
         logic ok, valid;
         valid = (m_t < 0) || (m_t == W);
         ok = (ready === (m_t < 0)) && (busy === (m_t >= 0 && m_t < W)) &&
              (done === (m_t == W)) && (bout === m_bout) &&
              (!valid || (d === m_d && bo === m_bo));
         vecs++;
         if (!ok) begin
            errs++;
            $display("FAIL cycle@%0t: got rdy=%b busy=%b done=%b d=%h bo=%b bout=%b, expected rdy=%b busy=%b done=%b d=%h bo=%b bout=%b (d/bo checked=%b)",
                     $time, ready, busy, done, d, bo, bout, m_t < 0, m_t >= 0 && m_t < W,
                     m_t == W, m_d, m_bo, m_bout, valid);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 30) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic op(input logic [W-1:0] ta, tb_, input logic tbi, input logic [W-1:0] ed,
                     input logic [W-2:0] ebo, input logic eb, input string nm);
      int n;
      @(negedge clk); a = ta; b = tb_; bi = tbi; start = 1'b1;
      @(negedge clk); start = 1'b0; a = W'($urandom); b = W'($urandom); bi = 1'($urandom);
      wait_done(n);
      chk({nm, " latency"}, n, W);
      chk({nm, " d"}, d, ed);
      chk({nm, " bo"}, bo, ebo);
      chk({nm, " bout"}, bout, eb);
      @(negedge clk);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, nd;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; bi = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset d", d, 0); chk("reset bo", bo, 0); chk("reset bout", bout, 0);
      chk("reset ready", ready, 1); chk("reset busy", busy, 0); chk("reset done", done, 0);
      rst = 1'b0; en = 1'b1;
      op(4'd9, 4'd3, 1'b0, 4'd6, 3'b110, 1'b0, "9-3");
      op(4'd3, 4'd9, 1'b0, 4'hA, 3'b000, 1'b1, "3-9");
      op(4'd0, 4'd0, 1'b1, 4'hF, 3'b111, 1'b1, "0-0-1");
      op(4'd15, 4'd15, 1'b1, 4'hF, 3'b111, 1'b1, "15-15-1");
      // start held high throughout; operands change mid-operation
      @(negedge clk); a = 4'd5; b = 4'd5; bi = 1'b0; start = 1'b1;
      @(negedge clk); a = 4'd0; b = 4'd0;
      wait_done(n);
      chk("hold latency", n, W); chk("hold d", d, 0); chk("hold bout", bout, 0);
      @(negedge clk); chk("hold idle done", done, 0); chk("hold idle ready", ready, 1);
      @(negedge clk); chk("hold reaccept busy", busy, 1); start = 1'b0;
      wait_done(n); chk("hold second d", d, 0);
      @(negedge clk);
      // asynchronous reset in the second SHIFT cycle
      @(negedge clk); a = 4'd9; b = 4'd3; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk); #1 rst = 1'b1;
      #1 chk("abort d", d, 0); chk("abort bo", bo, 0); chk("abort bout", bout, 0);
      chk("abort ready", ready, 1); chk("abort busy", busy, 0); chk("abort done", done, 0);
      @(negedge clk); rst = 1'b0;
      nd = 0;
      repeat (W + 2) begin @(negedge clk); nd += int'(done); end
      chk("abort no done", nd, 0);
      op(4'd7, 4'd2, 1'b0, 4'd5, 3'b000, 1'b0, "7-2");
      // back-to-back: start during DONE is ignored, next IDLE edge accepts
      @(negedge clk); a = 4'd1; b = 4'd2; bi = 1'b0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      wait_done(n);
      start = 1'b1; a = 4'd12; b = 4'd4;
      @(negedge clk); n = 1;
      @(negedge clk); n++; start = 1'b0;
      while (!done && n < 30) begin @(negedge clk); n++; end
      chk("b2b gap", n, W + 2); chk("b2b d", d, 4'd8);
      @(negedge clk);
      repeat (3000) begin
         @(negedge clk);
         #1 rst = ($urandom_range(0, 199) == 0);
         start = 1'($urandom); a = W'($urandom); b = W'($urandom); bi = 1'($urandom);
      end
      #1 rst = 1'b0; start = 1'b0;
      repeat (10) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
